im_fetch_ctrl: RTL and testbench
================================

// Module: im_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the combinational 256x16 instruction ROM (IM).
//  Owns the PC, drives the IM address, and registers fetched words into the IF/ID stage.
//  Handles stall, branch/jump redirect and HALT detection.
//  Arbitrates IM access between the fetch path and a debug read port.
// PARAMETERS
//  ADDR_W   8    IM address width; PC wraps modulo 2**ADDR_W
//  INSTR_W  16   instruction width
//  OP_HI    15   MSB of the opcode field; opcode = instr[OP_HI:OP_HI-4], compared with `HALT
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high
//  start        in   1        1-cycle pulse; begins fetching at start_pc
//  start_pc     in   ADDR_W   initial PC, sampled on start
//  enable       in   1        0 freezes the whole fetch stage (global run gate)
//  stall        in   1        hazard hold from decode; IF/ID and PC hold
//  redirect     in   1        taken branch/jump from execute
//  redirect_pc  in   ADDR_W   target PC
//  im_addr      out  ADDR_W   address to IM (combinational)
//  im_data      in   INSTR_W  IM read data (combinational, same cycle)
//  if_valid     out  1        IF/ID holds a live instruction
//  if_pc        out  ADDR_W   PC of if_instr
//  if_instr     out  INSTR_W  fetched instruction
//  halted       out  1        HALT was fetched; fetch stopped
//  dbg_req      in   1        debug read request (level)
//  dbg_addr     in   ADDR_W   debug read address
//  dbg_gnt      out  1        debug owns IM this cycle (combinational)
//  dbg_data     out  INSTR_W  registered IM word, valid the cycle after dbg_gnt
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, if_valid=0, if_pc=0, if_instr=0, halted=0, dbg_data=0.
//  FSM: IDLE -start-> RUN. RUN -HALT fetched-> HALT. HALT -start-> RUN. Any state -reset-> IDLE.
//   A start pulse is honoured only in IDLE or HALT; in RUN it is ignored.
//  On start: pc<=start_pc, if_valid<=0, halted<=0.
//  im_addr: dbg_addr when dbg_gnt=1, else pc.
//   dbg_gnt = dbg_req & (state!=RUN).
//   Fetch always has priority in RUN; dbg_req simply waits.
//  dbg_data <= im_data on every cycle with dbg_gnt=1 (1-cycle latency); otherwise it holds.
//  RUN step, when enable=1, evaluated in priority order:
//   1) redirect=1: pc<=redirect_pc, if_valid<=0 (flush).
//      Overrides stall. The word on im_data is discarded, even if it is a HALT.
//   2) stall=1: pc, if_pc, if_instr and if_valid all hold.
//   3) otherwise: if_instr<=im_data, if_pc<=pc, if_valid<=1, pc<=pc+1 (255 wraps to 0).
//  HALT fetched (step 3 with opcode==`HALT):
//   - the HALT word is still loaded with if_valid=1;
//   - pc holds; next state=HALT; halted<=1.
//  In HALT:
//   - if_valid<=0 on the first cycle in which stall=0;
//   - pc and if_* hold; stall and redirect are ignored.
//  enable=0: no register changes, except dbg_data (debug reads still work).
//  Latency: word at pc appears on if_instr 1 cycle after the fetch; 1 instr/cycle throughput.
//  Reset mid-run: asynchronous return to reset values; the in-flight word is dropped.
// STRUCTURE
//  Shared package/header (define.v): the `HALT opcode, plus the new state encodings
//   `IF_IDLE=2'd0, `IF_RUN=2'd1, `IF_HALT=2'd2.
//  No sub-module: the PC/next-PC mux, FSM, IF/ID register and debug mux all stay in this file.
//  The existing IM is instantiated by the top level, not inside this block.
// TESTING
//  T1 Reset then start with start_pc=0, program ADDI/ADDI/JUMP:
//     -> if_pc sequence 0,1,2 with if_valid=1 from cycle 1.
//  T2 redirect=1, redirect_pc=5 while pc=3:
//     -> next cycle if_valid=0 and pc=5; the cycle after, if_pc=5.
//  T3 stall held 3 cycles at if_pc=7:
//     -> if_pc/if_instr frozen at 7; pc stays 8; resumes with if_pc=8.
//     Also stall+redirect in the same cycle -> redirect wins.
//  T4 HALT word at address 18:
//     -> if_instr=HALT with if_valid=1 for 1 cycle, then if_valid=0, halted=1, pc=18.
//     HALT at an address with redirect in the same cycle -> halted stays 0.
//  T5 dbg_req, dbg_addr=4 in RUN:
//     -> dbg_gnt=0. After HALT: dbg_gnt=1 and dbg_data=IM[4] one cycle later.
//  T6 pc=255 without branch -> next pc=0.
//     Also: async reset asserted mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/im_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: the HALT opcode and
// the fetch FSM state encodings.
package im_fetch_ctrl_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] HALT_OP = 5'h1F;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

  function automatic logic is_halt(input logic [OPC_W-1:0] op);
    return op == HALT_OP;
  endfunction

endpackage

// File: rtl/im_fetch_ctrl_if.sv
// IM access bus plus the debug read port that shares it. The master side is the
// fetch controller; the slave side is the ROM and the debug requester.
interface im_fetch_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  im_addr;
  logic [INSTR_W-1:0] im_data;
  logic               dbg_req;
  logic [ADDR_W-1:0]  dbg_addr;
  logic               dbg_gnt;
  logic [INSTR_W-1:0] dbg_data;

  modport master (
    output im_addr,
    input  im_data,
    input  dbg_req,
    input  dbg_addr,
    output dbg_gnt,
    output dbg_data
  );

  modport slave (
    input  im_addr,
    output im_data,
    output dbg_req,
    output dbg_addr,
    input  dbg_gnt,
    input  dbg_data
  );
endinterface

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IM address, loads the
// IF/ID register and lets a debug port borrow the IM whenever fetch is idle.
module im_fetch_ctrl
  import im_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int OP_HI   = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               enable,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               halted,
  im_fetch_ctrl_if.master    bus
);

  if_state_e          state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic               vld_nxt, halted_nxt;
  logic [ADDR_W-1:0]  if_pc_nxt;
  logic [INSTR_W-1:0] if_instr_nxt;
  logic [OPC_W-1:0]   opcode;

  // Debug only borrows the IM outside RUN, so fetch never sees a bubble.
  assign bus.dbg_gnt = bus.dbg_req & (state != IF_RUN);
  assign bus.im_addr = bus.dbg_gnt ? bus.dbg_addr : pc;
  assign opcode      = bus.im_data[OP_HI -: OPC_W];

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    vld_nxt      = if_valid;
    if_pc_nxt    = if_pc;
    if_instr_nxt = if_instr;
    halted_nxt   = halted;
    if (enable) begin
      case (state)
        IF_IDLE: begin
          if (start) begin
            state_nxt  = IF_RUN;
            pc_nxt     = start_pc;
            vld_nxt    = 1'b0;
            halted_nxt = 1'b0;
          end
        end
        IF_RUN: begin
          if (redirect) begin
            // Flush: the word on im_data is dropped, HALT included.
            pc_nxt  = redirect_pc;
            vld_nxt = 1'b0;
          end else if (!stall) begin
            if_instr_nxt = bus.im_data;
            if_pc_nxt    = pc;
            vld_nxt      = 1'b1;
            if (is_halt(opcode)) begin
              state_nxt  = IF_HALT;
              halted_nxt = 1'b1;
            end else begin
              pc_nxt = pc + ADDR_W'(1);
            end
          end
        end
        IF_HALT: begin
          if (start) begin
            state_nxt  = IF_RUN;
            pc_nxt     = start_pc;
            vld_nxt    = 1'b0;
            halted_nxt = 1'b0;
          end else if (!stall) begin
            vld_nxt = 1'b0;
          end
        end
        default: state_nxt = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IF_IDLE;
      pc       <= '0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      if_valid <= vld_nxt;
      if_pc    <= if_pc_nxt;
      if_instr <= if_instr_nxt;
      halted   <= halted_nxt;
    end
  end

  // Debug capture ignores enable so the ROM stays readable while frozen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             bus.dbg_data <= '0;
    else if (bus.dbg_gnt)  bus.dbg_data <= bus.im_data;
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl with a combinational ROM model.
module tb_im_fetch_ctrl;
  import im_fetch_ctrl_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  start_pc = '0;
  logic               enable = 1'b1;
  logic               stall = 1'b0;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic               if_valid;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               halted;
  logic [INSTR_W-1:0] rom [0:255];

  int n_chk = 0;
  int n_err = 0;

  localparam logic [INSTR_W-1:0] HALT_W = 16'hF800;

  im_fetch_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  im_fetch_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OP_HI(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_pc    (start_pc),
    .enable      (enable),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .halted      (halted),
    .bus         (bus.master)
  );

  assign bus.im_data = rom[bus.im_addr];

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [INSTR_W-1:0] addi(input int a);
    return {5'h01, 3'b000, 8'(a)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = addi(i);
    rom[2]  = {5'h02, 3'b000, 8'd0};
    rom[18] = HALT_W;
    rom[31] = HALT_W;
    bus.dbg_req  = 1'b0;
    bus.dbg_addr = '0;

    // reset state
    #12;
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", 32'(if_pc), 0);
    chk("rst_instr", 32'(if_instr), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_dbg_data", 32'(bus.dbg_data), 0);
    chk("rst_im_addr", 32'(bus.im_addr), 0);
    reset = 1'b0;
    step();

    // T1: start at 0, sequential fetch
    start = 1'b1; start_pc = 8'd0;
    step();
    start = 1'b0;
    chk("t1_valid0", 32'(if_valid), 0);
    chk("t1_pc0", 32'(bus.im_addr), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_if_pc", 32'(if_pc), 32'(i));
      chk("t1_instr", 32'(if_instr), 32'(rom[i]));
      chk("t1_valid", 32'(if_valid), 1);
    end

    // T2: redirect at pc=3 to 5
    chk("t2_pc3", 32'(bus.im_addr), 3);
    redirect = 1'b1; redirect_pc = 8'd5;
    step();
    redirect = 1'b0;
    chk("t2_flush", 32'(if_valid), 0);
    chk("t2_pc5", 32'(bus.im_addr), 5);
    step();
    chk("t2_if_pc", 32'(if_pc), 5);
    chk("t2_valid", 32'(if_valid), 1);

    // T3: stall held 3 cycles at if_pc=7
    step(); step();
    chk("t3_if_pc7", 32'(if_pc), 7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_pc", 32'(if_pc), 7);
      chk("t3_hold_instr", 32'(if_instr), 32'(rom[7]));
      chk("t3_hold_valid", 32'(if_valid), 1);
      chk("t3_hold_fpc", 32'(bus.im_addr), 8);
    end
    stall = 1'b0;
    step();
    chk("t3_resume", 32'(if_pc), 8);

    // stall + redirect: redirect wins
    stall = 1'b1; redirect = 1'b1; redirect_pc = 8'd16;
    step();
    stall = 1'b0; redirect = 1'b0;
    chk("t3_sr_valid", 32'(if_valid), 0);
    chk("t3_sr_pc", 32'(bus.im_addr), 16);
    step();
    chk("t3_sr_if_pc", 32'(if_pc), 16);

    // T5a: debug denied in RUN
    bus.dbg_req = 1'b1; bus.dbg_addr = 8'd4;
    #1;
    chk("t5_gnt_run", 32'(bus.dbg_gnt), 0);
    chk("t5_addr_run", 32'(bus.im_addr), 17);
    bus.dbg_req = 1'b0;

    // T4: HALT at 18
    step();
    chk("t4_if_pc17", 32'(if_pc), 17);
    step();
    chk("t4_halt_instr", 32'(if_instr), 32'(HALT_W));
    chk("t4_halt_valid", 32'(if_valid), 1);
    chk("t4_halt_pc", 32'(if_pc), 18);
    chk("t4_halted", 32'(halted), 1);
    step();
    chk("t4_valid_off", 32'(if_valid), 0);
    chk("t4_halted2", 32'(halted), 1);
    chk("t4_pc18", 32'(bus.im_addr), 18);

    // T5b: debug granted after HALT
    bus.dbg_req = 1'b1; bus.dbg_addr = 8'd4;
    #1;
    chk("t5_gnt_halt", 32'(bus.dbg_gnt), 1);
    chk("t5_addr_halt", 32'(bus.im_addr), 4);
    step();
    chk("t5_dbg_data", 32'(bus.dbg_data), 32'(rom[4]));
    bus.dbg_req = 1'b0;

    // HALT word squashed by a same-cycle redirect
    start = 1'b1; start_pc = 8'd30;
    step();
    start = 1'b0;
    chk("t4r_halted_clr", 32'(halted), 0);
    chk("t4r_pc30", 32'(bus.im_addr), 30);
    step();
    chk("t4r_if_pc30", 32'(if_pc), 30);
    redirect = 1'b1; redirect_pc = 8'd40;
    step();
    redirect = 1'b0;
    chk("t4r_halted", 32'(halted), 0);
    chk("t4r_valid", 32'(if_valid), 0);
    chk("t4r_pc40", 32'(bus.im_addr), 40);

    // enable=0 freezes fetch
    step();
    chk("en_if_pc40", 32'(if_pc), 40);
    enable = 1'b0;
    step();
    chk("en_hold_if_pc", 32'(if_pc), 40);
    chk("en_hold_pc", 32'(bus.im_addr), 41);
    enable = 1'b1;

    // T6: PC wrap 255 -> 0
    redirect = 1'b1; redirect_pc = 8'd254;
    step();
    redirect = 1'b0;
    step();
    chk("t6_if_pc254", 32'(if_pc), 254);
    step();
    chk("t6_if_pc255", 32'(if_pc), 255);
    chk("t6_wrap_pc", 32'(bus.im_addr), 0);
    step();
    chk("t6_if_pc0", 32'(if_pc), 0);
    chk("t6_instr0", 32'(if_instr), 32'(rom[0]));

    // async reset mid-RUN
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(if_valid), 0);
    chk("ar_pc", 32'(if_pc), 0);
    chk("ar_instr", 32'(if_instr), 0);
    chk("ar_halted", 32'(halted), 0);
    chk("ar_dbg_data", 32'(bus.dbg_data), 0);
    chk("ar_im_addr", 32'(bus.im_addr), 0);
    reset = 1'b0;
    step();
    chk("ar_idle", 32'(if_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
